// File: rtl/uart_rx_module_if.sv
// Serial line, enable and received-byte signals between the UART receiver and its consumer.
interface uart_rx_module_if;
  logic       RX_Pin_In;
  logic       RX_En_Sig;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig;
  logic       RX_Err_Sig;

  modport master (
    output RX_Pin_In, RX_En_Sig,
    input  RX_Data, RX_Done_Sig, RX_Err_Sig
  );

  modport slave (
    input  RX_Pin_In, RX_En_Sig,
    output RX_Data, RX_Done_Sig, RX_Err_Sig
  );
endinterface

// File: rtl/uart_rx_module.sv
// UART receiver: 8N1 deframing, LSB first, midpoint sampling.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx_module #(
  parameter int unsigned BIT_PERIOD = 5208
) (
  input logic        CLK,
  input logic        RST_N,
  uart_rx_module_if.slave bus
);

  localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
  localparam int unsigned TW          = $clog2(BIT_PERIOD);
  localparam logic [TW-1:0] T_FULL    = TW'(BIT_PERIOD - 1);
  localparam logic [TW-1:0] T_HALF    = TW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          perr_q, perr_d;
  logic          sync1, sync2, hist;
  logic          start_edge;
  logic          frame_ok;

  // Two-flop synchronizer plus history flop for falling-edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= bus.RX_Pin_In;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign start_edge = hist & ~sync2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state and output logic; the timer restarts on every state change.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    perr_d   = perr_q;
    frame_ok = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        perr_d  = 1'b0;
        if (start_edge && bus.RX_En_Sig) state_d = S_START;
      end
      S_START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          state_d = sync2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          shift_d = {sync2, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          perr_d  = ^{sync2, shift_q};
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
`ifdef UART_RX_PARITY_EN
        frame_ok = sync2 & ~perr_q;
`else
        frame_ok = sync2;
`endif
        // Return to IDLE at the stop midpoint so the next start edge is never missed.
        if (timer_q == T_FULL) begin
          timer_d = '0;
          state_d = S_IDLE;
          if (frame_ok) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.RX_Data     = data_q;
  assign bus.RX_Done_Sig = done_q;
  assign bus.RX_Err_Sig  = err_q;

endmodule
